// File: rtl/prbs_pkg.sv
// Shared encodings for the PRBS BERT checker: polynomial selects, tap table, FSM states.
package prbs_pkg;

  localparam int HIST_W = 31;

  localparam logic [2:0] POLY_PRBS7  = 3'd0;
  localparam logic [2:0] POLY_PRBS9  = 3'd1;
  localparam logic [2:0] POLY_PRBS15 = 3'd2;
  localparam logic [2:0] POLY_PRBS23 = 3'd3;
  localparam logic [2:0] POLY_PRBS31 = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Tap pair (A,B): predicted bit = h[A-1] ^ h[B-1]
  typedef struct packed {
    logic [4:0] a;
    logic [4:0] b;
  } taps_t;

  function automatic taps_t poly_taps(input logic [2:0] sel);
    taps_t t;
    case (sel)
      POLY_PRBS9:  t = '{a: 5'd9,  b: 5'd5};
      POLY_PRBS15: t = '{a: 5'd15, b: 5'd14};
      POLY_PRBS23: t = '{a: 5'd23, b: 5'd18};
      POLY_PRBS31: t = '{a: 5'd31, b: 5'd28};
      default:     t = '{a: 5'd7,  b: 5'd6};
    endcase
    return t;
  endfunction

endpackage

// File: rtl/prbs_word_predict.sv
// One word of self-synchronising PRBS checking: predict, compare and shift each
// received bit, oldest (MSB) first.
module prbs_word_predict
  import prbs_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [HIST_W-1:0] hist,
  input  logic [DATA_W-1:0] din,
  input  taps_t             taps,
  output logic [HIST_W-1:0] hist_next,
  output logic [DATA_W-1:0] mismatch
);

  logic [HIST_W-1:0] h;
  logic              pred;

  // The received bit, not the prediction, feeds the history so errors self-flush.
  always_comb begin
    h        = hist;
    pred     = 1'b0;
    mismatch = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      pred        = h[taps.a - 5'd1] ^ h[taps.b - 5'd1];
      mismatch[i] = din[i] ^ pred;
      h           = {h[HIST_W-2:0], din[i]};
    end
    hist_next = h;
  end

endmodule

// File: rtl/prbs_bert_checker.sv
// PRBS bit-error-rate checker: search/lock FSM plus saturating bit and error
// counters that advance only while locked.
module prbs_bert_checker
  import prbs_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 32,
  parameter int LOCK_GOOD = 16,
  parameter int LOCK_BAD  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [2:0]        poly_sel,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              clear_cnt,
  output logic              locked,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  bit_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              err_pulse
);

  localparam int EC_W = $clog2(DATA_W + 1);
  localparam int GR_W = $clog2(LOCK_GOOD + 1);
  localparam int BR_W = $clog2(LOCK_BAD + 1);

  state_t            st;
  taps_t             taps;
  logic [HIST_W-1:0] hist, hist_next, amask;
  logic [DATA_W-1:0] mis;
  logic [EC_W-1:0]   werr;
  logic              word_good;
  logic [GR_W-1:0]   good_run;
  logic [BR_W-1:0]   bad_run;
  logic [CNT_W:0]    bit_sum, err_sum;
  logic [CNT_W-1:0]  bit_nxt, err_nxt;

  prbs_word_predict #(.DATA_W(DATA_W)) u_pred (
    .hist      (hist),
    .din       (din),
    .taps      (taps),
    .hist_next (hist_next),
    .mismatch  (mis)
  );

  always_comb begin
    werr = '0;
    for (int i = 0; i < DATA_W; i++) werr = werr + EC_W'(mis[i]);
  end

  // A clean word over an all-zero register would lock onto a dead line.
  assign amask     = (HIST_W'(1) << taps.a) - HIST_W'(1);
  assign word_good = (werr == '0) && |(hist_next & amask);

  assign bit_sum = {1'b0, bit_cnt} + (CNT_W + 1)'(DATA_W);
  assign err_sum = {1'b0, err_cnt} + (CNT_W + 1)'(werr);
  assign bit_nxt = bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
  assign err_nxt = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];

  assign state = st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= ST_IDLE;
      taps      <= poly_taps(POLY_PRBS7);
      hist      <= '0;
      good_run  <= '0;
      bad_run   <= '0;
      locked    <= 1'b0;
      bit_cnt   <= '0;
      err_cnt   <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      case (st)
        ST_IDLE: begin
          hist     <= '0;
          taps     <= poly_taps(poly_sel);
          good_run <= '0;
          bad_run  <= '0;
          locked   <= 1'b0;
          if (enable) st <= ST_SEARCH;
        end
        ST_SEARCH: begin
          if (!enable) begin
            st <= ST_IDLE;
          end else if (din_valid) begin
            hist <= hist_next;
            if (!word_good) begin
              good_run <= '0;
            end else if (good_run == GR_W'(LOCK_GOOD - 1)) begin
              st       <= ST_LOCKED;
              locked   <= 1'b1;
              good_run <= '0;
              bad_run  <= '0;
            end else begin
              good_run <= good_run + GR_W'(1);
            end
          end
        end
        ST_LOCKED: begin
          if (!enable) begin
            st     <= ST_IDLE;
            locked <= 1'b0;
          end else if (din_valid) begin
            hist      <= hist_next;
            bit_cnt   <= bit_nxt;
            err_cnt   <= err_nxt;
            err_pulse <= (werr != '0);
            if (werr == '0) begin
              bad_run <= '0;
            end else if (bad_run == BR_W'(LOCK_BAD - 1)) begin
              st       <= ST_SEARCH;
              locked   <= 1'b0;
              bad_run  <= '0;
              good_run <= '0;
            end else begin
              bad_run <= bad_run + BR_W'(1);
            end
          end
        end
        default: begin
          st     <= ST_IDLE;
          locked <= 1'b0;
        end
      endcase
      // Clear overrides any same-cycle accumulation.
      if (clear_cnt) begin
        bit_cnt <= '0;
        err_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_prbs_bert_checker.sv
// Directed bench: PRBS7/8-bit instance for lock, errors, clear and zero guard;
// PRBS15/16-bit instance with 8-bit counters for saturation.
module tb_prbs_bert_checker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        en_a, vld_a, clr_a, locked_a, pulse_a;
  logic [2:0]  poly_a;
  logic [7:0]  din_a;
  logic [1:0]  state_a;
  logic [31:0] bit_a, err_a;

  logic        en_b, vld_b, clr_b, locked_b, pulse_b;
  logic [2:0]  poly_b;
  logic [15:0] din_b;
  logic [1:0]  state_b;
  logic [7:0]  bit_b, err_b;

  prbs_bert_checker #(.DATA_W(8)) u_a (
    .clk(clk), .rst(rst), .enable(en_a), .poly_sel(poly_a), .din(din_a),
    .din_valid(vld_a), .clear_cnt(clr_a), .locked(locked_a), .state(state_a),
    .bit_cnt(bit_a), .err_cnt(err_a), .err_pulse(pulse_a)
  );

  prbs_bert_checker #(.DATA_W(16), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .enable(en_b), .poly_sel(poly_b), .din(din_b),
    .din_valid(vld_b), .clear_cnt(clr_b), .locked(locked_b), .state(state_b),
    .bit_cnt(bit_b), .err_cnt(err_b), .err_pulse(pulse_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference LFSR: next bit = s[ta-1]^s[tb-1], emitted MSB first.
  task automatic gen(input int ta, input int tbp, input int n,
                     inout logic [30:0] s, output logic [31:0] w);
    logic nb;
    w = '0;
    for (int i = n - 1; i >= 0; i--) begin
      nb   = s[ta-1] ^ s[tbp-1];
      w[i] = nb;
      s    = {s[29:0], nb};
    end
  endtask

  logic [30:0] ga, gb;
  logic [31:0] wd;
  logic [31:0] snap;
  int          pc;
  logic        lk;

  initial begin
    rst = 1'b1;
    en_a = 0; vld_a = 0; clr_a = 0; poly_a = 3'd0; din_a = '0;
    en_b = 0; vld_b = 0; clr_b = 0; poly_b = 3'd0; din_b = '0;
    repeat (2) tick;
    rst = 1'b0;
    tick;
    chk("rst_state", state_a, 0);
    chk("rst_locked", locked_a, 0);
    chk("rst_bit_cnt", bit_a, 0);
    chk("rst_err_cnt", err_a, 0);
    chk("rst_err_pulse", pulse_a, 0);

    en_a = 1'b1;
    tick;
    chk("enter_search", state_a, 1);

    // Clean PRBS7: word 1 errs (empty history), words 2..17 lock, word 18 counted.
    ga = 31'h7F;
    vld_a = 1'b1;
    for (int w = 1; w <= 18; w++) begin
      gen(7, 6, 8, ga, wd);
      din_a = wd[7:0];
      tick;
    end
    chk("lock_by_w18", locked_a, 1);
    chk("bit_cnt_w18", bit_a, 8);

    pc = 0;
    for (int w = 0; w < 10; w++) begin
      gen(7, 6, 8, ga, wd);
      din_a = wd[7:0];
      tick;
      pc += int'(pulse_a);
    end
    chk("clean_bit_cnt", bit_a, 88);
    chk("clean_err_cnt", err_a, 0);
    chk("clean_no_pulse", pc, 0);

    // Single flip at stream position 3; tap echoes land in the next word.
    pc = 0;
    for (int w = 0; w < 5; w++) begin
      gen(7, 6, 8, ga, wd);
      din_a = (w == 0) ? (wd[7:0] ^ 8'h10) : wd[7:0];
      tick;
      pc += int'(pulse_a);
    end
    chk("flip_err_cnt", err_a, 3);
    chk("flip_locked", locked_a, 1);
    chk("flip_pulses", pc, 2);
    chk("flip_bit_cnt", bit_a, 128);

    // Four complemented words: every word errs, lock lost after the fourth.
    pc = 0;
    for (int w = 1; w <= 4; w++) begin
      gen(7, 6, 8, ga, wd);
      din_a = ~wd[7:0];
      tick;
      pc += int'(pulse_a);
      if (w == 3) chk("still_locked_w3", locked_a, 1);
    end
    chk("unlock_w4", locked_a, 0);
    chk("unlock_state", state_a, 1);
    chk("bad_pulses", pc, 4);
    chk("bad_bit_cnt", bit_a, 160);
    chk("bad_err_grew", err_a > 32'd3, 1);
    snap = err_a;

    for (int w = 0; w < 3; w++) begin
      gen(7, 6, 8, ga, wd);
      din_a = wd[7:0];
      tick;
    end
    chk("search_bit_hold", bit_a, 160);
    chk("search_err_hold", err_a, snap);

    for (int w = 0; w < 40 && !locked_a; w++) begin
      gen(7, 6, 8, ga, wd);
      din_a = wd[7:0];
      tick;
    end
    chk("relock", locked_a, 1);

    gen(7, 6, 8, ga, wd);
    din_a = wd[7:0];
    clr_a = 1'b1;
    tick;
    clr_a = 1'b0;
    chk("clear_bit_cnt", bit_a, 0);
    chk("clear_err_cnt", err_a, 0);
    chk("clear_state", state_a, 2);
    gen(7, 6, 8, ga, wd);
    din_a = wd[7:0];
    tick;
    chk("post_clear_bit", bit_a, 8);

    en_a = 1'b0;
    vld_a = 1'b0;
    tick;
    chk("disable_idle", state_a, 0);
    chk("disable_bit_hold", bit_a, 8);

    // All-zero line must never lock.
    en_a = 1'b1;
    tick;
    din_a = 8'h00;
    vld_a = 1'b1;
    lk = 1'b0;
    for (int w = 0; w < 100; w++) begin
      tick;
      lk |= locked_a;
    end
    chk("zero_never_locked", lk, 0);
    chk("zero_state_search", state_a, 1);

    rst = 1'b1;
    #2;
    chk("midrst_bit_cnt", bit_a, 0);
    chk("midrst_state", state_a, 0);
    @(negedge clk);
    rst = 1'b0;
    en_a = 1'b0;
    vld_a = 1'b0;
    tick;

    // PRBS15, 16-bit words, 8-bit counters: drive both counters into saturation.
    poly_b = 3'd2;
    en_b = 1'b1;
    tick;
    gb = 31'h7FFF;
    vld_b = 1'b1;
    for (int w = 0; w < 60 && !locked_b; w++) begin
      gen(15, 14, 16, gb, wd);
      din_b = wd[15:0];
      tick;
    end
    chk("b_locked", locked_b, 1);
    for (int k = 0; k < 100; k++) begin
      for (int j = 0; j < 3; j++) begin
        gen(15, 14, 16, gb, wd);
        din_b = (j == 0) ? (wd[15:0] ^ (16'h1 << $urandom_range(0, 15))) : wd[15:0];
        tick;
      end
    end
    chk("b_err_sat", err_b, 255);
    chk("b_bit_sat", bit_b, 255);
    chk("b_still_locked", locked_b, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prbs_bert_checker.md
Name: prbs_bert_checker

Overview:
- Parametrised, self-synchronising PRBS bit-error-rate checker for the BERT path.
- Accepts DATA_W received bits per clock, with polynomial selectable at run time.
- Acquires lock with a search/lock state machine, then accumulates saturating bit and error counters for BER readout.
- Sits downstream of the deserialiser that recovers the lpGBT e-link (FAST_CMD) stream. It generalises the fixed 8-bit PRBS source used in the bench to any word width and five standard polynomials.

Parameters:
DATA_W, 8, received bits per valid word; legal range 1..32
CNT_W, 32, width of bit_cnt and err_cnt
LOCK_GOOD, 16, consecutive error-free words required to declare lock
LOCK_BAD, 4, consecutive erroneous words required to lose lock

Ports:
clk  in  1  checker clock (deserialised word clock)
rst  in  1  asynchronous, active-high reset
enable  in  1  0 forces IDLE; 1 runs the checker
poly_sel  in  3  0=PRBS7 (x^7+x^6+1), 1=PRBS9 (x^9+x^5+1), 2=PRBS15 (x^15+x^14+1), 3=PRBS23 (x^23+x^18+1), 4=PRBS31 (x^31+x^28+1); 5..7 decode as PRBS7
din  in  DATA_W  received bits; din[DATA_W-1] is the oldest (first on the line)
din_valid  in  1  din is valid this cycle
clear_cnt  in  1  synchronous clear of bit_cnt/err_cnt
locked  out  1  high in LOCKED state
state  out  2  0=IDLE, 1=SEARCH, 2=LOCKED
bit_cnt  out  CNT_W  bits checked while locked; saturating
err_cnt  out  CNT_W  bit errors while locked; saturating
err_pulse  out  1  one-cycle pulse: last locked word had >=1 error

Behaviour:
- Reset: state=IDLE, locked=0, bit_cnt=0, err_cnt=0, err_pulse=0, history=0, good/bad run counters=0.
- History: 31-bit shift register of received bits, where h[0] is the newest. Each bit of din is processed MSB to LSB within one cycle.
  - For each bit: pred = h[A-1]^h[B-1], where (A,B) are the taps of the latched polynomial.
  - mismatch = bit^pred. The received bit (not pred) is then shifted in.
- Word error count: popcount of the DATA_W mismatches, width clog2(DATA_W+1).
- Zero guard: a word is "good" only if the mismatch count is 0 and the post-update history (low A bits) is non-zero. All-zero input never locks.
- Latency: every output is registered and reflects the word sampled one cycle earlier. When din_valid=0, history, counters and run counters all hold.
- IDLE:
  - History is cleared and poly_sel is latched every cycle.
  - Move to SEARCH when enable=1. poly_sel changes outside IDLE are ignored.
- SEARCH:
  - A good word increments good_run; a bad word clears it.
  - Move to LOCKED when good_run reaches LOCK_GOOD on a valid word; bad_run clears on entry.
  - Counters do not advance in SEARCH.
- LOCKED, per valid word:
  - bit_cnt += DATA_W and err_cnt += word error count; each saturates at 2^CNT_W-1 and never wraps.
  - err_pulse=1 if the word error count is >0.
  - An erroneous word increments bad_run; a clean word clears it.
  - When bad_run reaches LOCK_BAD, move to SEARCH with good_run=0. The counters keep their values.
- enable=0 from any state: move to IDLE next cycle; the counters keep their values.
- clear_cnt: both counters are 0 the next cycle. If clear_cnt and a valid locked word arrive together, clear wins and that word is not counted. The state machine is unaffected.
- rst mid-operation: immediate return to reset values, including the counters.

Decomposition:
- Package prbs_pkg holds:
  - the poly_sel encoding constants;
  - the tap table (A,B) per polynomial;
  - the state encoding constants IDLE/SEARCH/LOCKED.
- Sub-module prbs_word_predict: combinational unroll of DATA_W predict/compare/shift steps. Inputs are history, din and taps; outputs are next history and the mismatch vector.
- The top level holds the FSM, run counters, popcount and saturating counters.

Test Plan:
- PRBS7, DATA_W=8, clean continuous stream from an x^7+x^6+1 LFSR, enable=1 -> locked=1 no later than the cycle after word 18; thereafter bit_cnt +8 per word, err_cnt=0, err_pulse never asserts.
- While locked on PRBS7, flip one isolated bit -> err_cnt increases by exactly 3 (the bit plus two tap echoes); locked stays 1; err_pulse is high for 1 or 2 cycles.
- din=0 for 100 valid words -> state stays SEARCH and locked=0 (zero guard).
- While locked, 4 consecutive words of uncorrelated random data -> err_pulse high 4 cycles; locked=0 the cycle after word 4; counters hold afterwards.
- CNT_W=8, PRBS15, DATA_W=16, locked, continuous random corruption -> err_cnt saturates at 255 and holds; bit_cnt saturates at 255.
- clear_cnt asserted together with a valid locked word -> bit_cnt=0 and err_cnt=0 next cycle; that word is not counted; state remains LOCKED.
